// File: rtl/ysyx_24120013_pkg.sv
// Shared encodings, FSM states and register-file sizing for the multi-cycle core.
// Defining YSYX_24120013_RV32E_EN selects the 16-register RV32E file and its index check.
package ysyx_24120013_pkg;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_t;

`ifdef YSYX_24120013_RV32E_EN
   localparam int NR_REGS = 16;
   localparam bit RV32E   = 1'b1;
`else
   localparam int NR_REGS = 32;
   localparam bit RV32E   = 1'b0;
`endif

   // Legal = supported encoding and, on RV32E, no used register field above x15.
   function automatic logic insn_legal(input logic [31:0] i);
      logic ok, rd_u, rs1_u, rs2_u;
      ok = 1'b0; rd_u = 1'b0; rs1_u = 1'b0; rs2_u = 1'b0;
      case (i[6:0])
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            ok = 1'b1; rd_u = 1'b1;
         end
         OPC_OP_IMM, OPC_JALR: begin
            ok = (i[14:12] == 3'b000); rd_u = 1'b1; rs1_u = 1'b1;
         end
         OPC_OP: begin
            ok = (i[14:12] == 3'b000) && (i[31:25] == 7'b0);
            rd_u = 1'b1; rs1_u = 1'b1; rs2_u = 1'b1;
         end
         OPC_SYSTEM: ok = (i == EBREAK);
         default: ok = 1'b0;
      endcase
      if (RV32E && ((rd_u && i[11]) || (rs1_u && i[19]) || (rs2_u && i[24])))
         ok = 1'b0;
      return ok;
   endfunction
endpackage

// File: rtl/ysyx_24120013_gpr.sv
// General-purpose register file: two async read ports, one sync write port, x0 reads zero.
// Latency: reads combinational, writes land at the clock edge; no backpressure.
// Backpressure: none, the write enable is always accepted.
module ysyx_24120013_gpr #(
   parameter int XLEN    = 32,
   parameter int NR_REGS = 32,
   parameter int AW      = $clog2(NR_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);
   logic [XLEN-1:0] regs [NR_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/ysyx_24120013_core_mc.sv
// Multi-cycle RV32I-subset core (lui/auipc/addi/add/jal/jalr/ebreak); YSYX_24120013_RV32E_EN selects RV32E.
// Latency: 2 cycles per instruction plus fetch wait states; results land at the EXEC edge.
// Backpressure: FETCH holds ifetch_req/ifetch_addr stable until ifetch_valid is seen.
module ysyx_24120013_core_mc
   import ysyx_24120013_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ifetch_req,
   output logic [XLEN-1:0] ifetch_addr,
   input  logic            ifetch_valid,
   input  logic [31:0]     ifetch_data,
   output logic [XLEN-1:0] pc,
   output logic            commit,
   output logic            halt,
   output logic [XLEN-1:0] halt_code,
   output logic            illegal
);
   localparam int AW = $clog2(NR_REGS);

   state_t          state;
   logic [31:0]     ir;
   logic            legal, is_ebreak, wen_dec, wen;
   logic [AW-1:0]   rs2_a;
   logic [XLEN-1:0] rs1_dat, rs2_dat, wdat, npc, pc_seq, jalr_sum;
   logic [XLEN-1:0] imm_i, imm_u, imm_j;

   assign ifetch_addr = pc;
   assign legal       = insn_legal(ir);
   assign is_ebreak   = (ir == EBREAK);
   assign wen         = (state == ST_EXEC) && legal && wen_dec;
   // ebreak has no rs2, so its second read port fetches a0 for halt_code.
   assign rs2_a       = is_ebreak ? AW'(10) : ir[20 +: AW];

   ysyx_24120013_gpr #(.XLEN(XLEN), .NR_REGS(NR_REGS), .AW(AW)) u_gpr (
      .clk (clk),
      .rst (rst),
      .ra1 (ir[15 +: AW]),
      .ra2 (rs2_a),
      .rd1 (rs1_dat),
      .rd2 (rs2_dat),
      .we  (wen),
      .wa  (ir[7 +: AW]),
      .wd  (wdat)
   );

   assign imm_i    = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_u    = {ir[31:12], 12'b0};
   assign imm_j    = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
   assign pc_seq   = pc + XLEN'(4);
   assign jalr_sum = rs1_dat + imm_i;

   always_comb begin
      wen_dec = 1'b0;
      wdat    = '0;
      npc     = pc_seq;
      case (ir[6:0])
         OPC_LUI:    begin wen_dec = 1'b1; wdat = imm_u;             end
         OPC_AUIPC:  begin wen_dec = 1'b1; wdat = pc + imm_u;        end
         OPC_OP_IMM: begin wen_dec = 1'b1; wdat = rs1_dat + imm_i;   end
         OPC_OP:     begin wen_dec = 1'b1; wdat = rs1_dat + rs2_dat; end
         OPC_JAL: begin
            wen_dec = 1'b1; wdat = pc_seq; npc = pc + imm_j;
         end
         OPC_JALR: begin
            wen_dec = 1'b1; wdat = pc_seq; npc = jalr_sum & ~XLEN'(1);
         end
         default: wen_dec = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         ir         <= '0;
         ifetch_req <= 1'b0;
         commit     <= 1'b0;
         halt       <= 1'b0;
         halt_code  <= '0;
         illegal    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state      <= ST_FETCH;
               ifetch_req <= 1'b1;
            end
            ST_FETCH: if (ifetch_valid) begin
               // commit is decided from the incoming word so it is high for the whole EXEC cycle.
               ir         <= ifetch_data;
               commit     <= insn_legal(ifetch_data);
               ifetch_req <= 1'b0;
               state      <= ST_EXEC;
            end
            ST_EXEC: begin
               commit <= 1'b0;
               if (!legal) begin
                  halt    <= 1'b1;
                  illegal <= 1'b1;
                  state   <= ST_HALT;
               end else if (is_ebreak) begin
                  halt      <= 1'b1;
                  halt_code <= rs2_dat;
                  state     <= ST_HALT;
               end else begin
                  pc         <= npc;
                  ifetch_req <= 1'b1;
                  state      <= ST_FETCH;
               end
            end
            default: state <= ST_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_24120013_core_mc.sv
// Directed bench for the multi-cycle core: small programs in a word memory with programmable wait states.
module tb_ysyx_24120013_core_mc;
   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] I_EBRK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifetch_req, ifetch_valid, commit, halt, illegal;
   logic [31:0] ifetch_addr, ifetch_data, pc, halt_code;

   logic [31:0] mem [64];
   int          wait_cycles = 0;
   int          checks = 0;
   int          errors = 0;
   int          ncommit = 0;
   logic [31:0] trace [$];

   ysyx_24120013_core_mc dut (
      .clk          (clk),
      .rst          (rst),
      .ifetch_req   (ifetch_req),
      .ifetch_addr  (ifetch_addr),
      .ifetch_valid (ifetch_valid),
      .ifetch_data  (ifetch_data),
      .pc           (pc),
      .commit       (commit),
      .halt         (halt),
      .halt_code    (halt_code),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   // Memory responder: answers a held request after wait_cycles idle cycles.
   initial begin : responder
      int          cnt;
      logic [31:0] off;
      cnt = 0;
      ifetch_valid = 1'b0;
      ifetch_data  = '0;
      forever begin
         @(negedge clk);
         if (ifetch_req && !rst) begin
            if (cnt >= wait_cycles) begin
               off = ifetch_addr - RST_PC;
               ifetch_valid = 1'b1;
               ifetch_data  = (off < 32'd256) ? mem[off[7:2]] : 32'h0;
            end else begin
               ifetch_valid = 1'b0;
               cnt++;
            end
         end else begin
            ifetch_valid = 1'b0;
            cnt = 0;
         end
      end
   end

   task automatic prep();
      rst = 1'b1;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
   endtask

   task automatic go(input int waits);
      wait_cycles = waits;
      ncommit = 0;
      trace.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (commit) begin
         ncommit++;
         trace.push_back(pc);
      end
   endtask

   task automatic run_to_halt(input int budget);
      int n;
      n = 0;
      while (!halt && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (halt !== 1'b1) begin
         errors++;
         $display("FAIL halt_timeout: halt=%b after %0d cycles, required 1", halt, n);
      end
   endtask

   task automatic load_addi_prog();
      mem[0] = 32'h0050_0093;   // addi x1,x0,5
      mem[1] = 32'h0000_8533;   // add  x10,x1,x0
      mem[2] = I_EBRK;
   endtask

   task automatic test_reset();
      prep();
      repeat (3) @(negedge clk);
      checks += 7;
      if (ifetch_req !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b required 0", ifetch_req); end
      if (ifetch_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h required %h", ifetch_addr, RST_PC); end
      if (pc !== RST_PC)        begin errors++; $display("FAIL rst_pc: got %h required %h", pc, RST_PC); end
      if (commit !== 1'b0)      begin errors++; $display("FAIL rst_commit: got %b required 0", commit); end
      if (halt !== 1'b0)        begin errors++; $display("FAIL rst_halt: got %b required 0", halt); end
      if (halt_code !== 32'h0)  begin errors++; $display("FAIL rst_code: got %h required 0", halt_code); end
      if (illegal !== 1'b0)     begin errors++; $display("FAIL rst_illegal: got %b required 0", illegal); end
   endtask

   task automatic test_zero_wait();
      prep();
      load_addi_prog();
      go(0);
      tick();
      checks += 3;
      if (ifetch_req !== 1'b1)    begin errors++; $display("FAIL zw_req: got %b required 1", ifetch_req); end
      if (ifetch_addr !== RST_PC) begin errors++; $display("FAIL zw_addr: got %h required %h", ifetch_addr, RST_PC); end
      if (commit !== 1'b0)        begin errors++; $display("FAIL zw_commit_early: got %b required 0", commit); end
      tick();
      checks += 2;
      if (commit !== 1'b1) begin errors++; $display("FAIL zw_commit: got %b required 1", commit); end
      if (pc !== RST_PC)   begin errors++; $display("FAIL zw_pc_exec: got %h required %h", pc, RST_PC); end
      tick();
      checks += 2;
      if (pc !== RST_PC + 32'd4) begin errors++; $display("FAIL zw_pc_next: got %h required %h", pc, RST_PC + 32'd4); end
      if (commit !== 1'b0)       begin errors++; $display("FAIL zw_commit_pulse: got %b required 0", commit); end
      run_to_halt(50);
      checks += 2;
      if (halt_code !== 32'd5) begin errors++; $display("FAIL zw_x1: got %h required 5", halt_code); end
      if (ncommit !== 3)       begin errors++; $display("FAIL zw_ncommit: got %0d required 3", ncommit); end
   endtask

   task automatic test_wait_states();
      int n_req, bad_addr, n;
      prep();
      load_addi_prog();
      go(3);
      tick();
      n_req = 0; bad_addr = 0; n = 0;
      while (!commit && n < 20) begin
         if (ifetch_req) n_req++;
         if (ifetch_addr !== RST_PC) bad_addr++;
         tick();
         n++;
      end
      checks += 4;
      if (n_req !== 4)    begin errors++; $display("FAIL ws_req_cycles: got %0d required 4", n_req); end
      if (bad_addr !== 0) begin errors++; $display("FAIL ws_addr_stable: got %0d changes required 0", bad_addr); end
      if (ncommit !== 1)  begin errors++; $display("FAIL ws_first_commit: got %0d required 1", ncommit); end
      if (pc !== RST_PC)  begin errors++; $display("FAIL ws_pc: got %h required %h", pc, RST_PC); end
      run_to_halt(100);
      checks += 2;
      if (halt_code !== 32'd5) begin errors++; $display("FAIL ws_x1: got %h required 5", halt_code); end
      if (ncommit !== 3)       begin errors++; $display("FAIL ws_ncommit: got %0d required 3", ncommit); end
   endtask

   task automatic test_sequence();
      logic [31:0] exp_off [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h14, 32'h18, 32'h10};
      prep();
      mem[0] = 32'h0050_0093;   // addi x1,x0,5
      mem[1] = 32'h1234_5137;   // lui  x2,0x12345
      mem[2] = 32'h0020_81B3;   // add  x3,x1,x2
      mem[3] = 32'h0080_00EF;   // jal  x1,8
      mem[4] = I_EBRK;          // reached through jalr
      mem[5] = 32'h0001_8533;   // add  x10,x3,x0
      mem[6] = 32'h0000_8067;   // jalr x0,0(x1)
      go(1);
      run_to_halt(200);
      checks += 2;
      if (halt_code !== 32'h1234_5005) begin errors++; $display("FAIL seq_x3: got %h required 12345005", halt_code); end
      if (ncommit !== 7) begin errors++; $display("FAIL seq_ncommit: got %0d required 7", ncommit); end
      for (int i = 0; i < 7 && i < ncommit; i++) begin
         checks++;
         if (trace[i] !== RST_PC + exp_off[i]) begin
            errors++;
            $display("FAIL seq_pc[%0d]: got %h required %h", i, trace[i], RST_PC + exp_off[i]);
         end
      end
   endtask

   task automatic test_jalr_same_reg();
      prep();
      mem[0] = 32'h0000_0097;   // auipc x1,0
      mem[1] = 32'h00D0_80E7;   // jalr  x1,13(x1): target bit 0 cleared
      mem[2] = I_EBRK;          // skipped
      mem[3] = 32'h0000_8533;   // add   x10,x1,x0
      mem[4] = I_EBRK;
      go(0);
      run_to_halt(100);
      checks += 3;
      if (halt_code !== 32'h8000_0008) begin errors++; $display("FAIL jalr_link: got %h required 80000008", halt_code); end
      if (pc !== RST_PC + 32'h10) begin errors++; $display("FAIL jalr_pc: got %h required %h", pc, RST_PC + 32'h10); end
      if (ncommit !== 4) begin errors++; $display("FAIL jalr_ncommit: got %0d required 4", ncommit); end
   endtask

   task automatic test_ebreak();
      int req_seen;
      prep();
      mem[0] = 32'hFFF0_0513;   // addi x10,x0,-1
      mem[1] = I_EBRK;
      go(0);
      run_to_halt(50);
      checks += 4;
      if (halt_code !== 32'hFFFF_FFFF) begin errors++; $display("FAIL eb_code: got %h required ffffffff", halt_code); end
      if (illegal !== 1'b0) begin errors++; $display("FAIL eb_illegal: got %b required 0", illegal); end
      if (ncommit !== 2)    begin errors++; $display("FAIL eb_ncommit: got %0d required 2", ncommit); end
      if (pc !== RST_PC + 32'd4) begin errors++; $display("FAIL eb_pc: got %h required %h", pc, RST_PC + 32'd4); end
      req_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifetch_req !== 1'b0 || halt !== 1'b1) req_seen++;
      end
      checks++;
      if (req_seen !== 0) begin errors++; $display("FAIL eb_absorbing: got %0d bad cycles required 0", req_seen); end
   endtask

   task automatic test_illegal();
      prep();
      go(1);                    // mem[0] = 0x00000000
      run_to_halt(50);
      checks += 4;
      if (illegal !== 1'b1) begin errors++; $display("FAIL il_flag: got %b required 1", illegal); end
      if (ncommit !== 0)    begin errors++; $display("FAIL il_commit: got %0d required 0", ncommit); end
      if (pc !== RST_PC)    begin errors++; $display("FAIL il_pc: got %h required %h", pc, RST_PC); end
      if (halt_code !== 32'h0) begin errors++; $display("FAIL il_code: got %h required 0", halt_code); end
   endtask

   task automatic test_reg_index();
      prep();
      mem[0] = 32'h0010_0813;   // addi x16,x0,1
      mem[1] = 32'h0008_0533;   // add  x10,x16,x0
      mem[2] = I_EBRK;
      go(0);
      run_to_halt(50);
`ifdef YSYX_24120013_RV32E_EN
      checks += 3;
      if (illegal !== 1'b1) begin errors++; $display("FAIL e_illegal: got %b required 1", illegal); end
      if (ncommit !== 0)    begin errors++; $display("FAIL e_commit: got %0d required 0", ncommit); end
      if (pc !== RST_PC)    begin errors++; $display("FAIL e_pc: got %h required %h", pc, RST_PC); end
`else
      checks += 2;
      if (illegal !== 1'b0)    begin errors++; $display("FAIL x16_illegal: got %b required 0", illegal); end
      if (halt_code !== 32'd1) begin errors++; $display("FAIL x16_value: got %h required 1", halt_code); end
`endif
   endtask

   task automatic test_reset_midfetch();
      prep();
      load_addi_prog();
      go(0);
      for (int i = 0; i < 6 && ncommit == 0; i++) tick();
      wait_cycles = 20;
      tick();
      checks += 2;
      if (ifetch_req !== 1'b1) begin errors++; $display("FAIL mf_req_wait: got %b required 1", ifetch_req); end
      if (ifetch_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL mf_addr_wait: got %h required %h", ifetch_addr, RST_PC + 32'd4); end
      #2 rst = 1'b1;
      #1;
      checks += 4;
      if (ifetch_req !== 1'b0) begin errors++; $display("FAIL mf_req_rst: got %b required 0", ifetch_req); end
      if (pc !== RST_PC)       begin errors++; $display("FAIL mf_pc_rst: got %h required %h", pc, RST_PC); end
      if (ifetch_addr !== RST_PC) begin errors++; $display("FAIL mf_addr_rst: got %h required %h", ifetch_addr, RST_PC); end
      if (commit !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL mf_flags_rst: got commit=%b halt=%b required 0/0", commit, halt); end
      go(0);
      #1;
      checks++;
      if (ifetch_req !== 1'b0) begin errors++; $display("FAIL mf_idle: got %b required 0", ifetch_req); end
      tick();
      checks += 2;
      if (ifetch_req !== 1'b1) begin errors++; $display("FAIL mf_restart_req: got %b required 1", ifetch_req); end
      if (ifetch_addr !== RST_PC) begin errors++; $display("FAIL mf_restart_addr: got %h required %h", ifetch_addr, RST_PC); end
      run_to_halt(50);
      checks++;
      if (halt_code !== 32'd5) begin errors++; $display("FAIL mf_result: got %h required 5", halt_code); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_sequence();
      test_jalr_same_reg();
      test_ebreak();
      test_illegal();
      test_reg_index();
      test_reset_midfetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
